// File: rtl/mips_dmem_bridge_if.sv
// ---------------------------------------------------------------------------
// mips_dmem_bridge_if
//
// Bus side of the MIPS data-memory bridge: one request channel and one
// response strobe.
//
// Handshake rules:
//   * A request transfers on a rising clk edge where bus_req_valid=1 and
//     bus_req_ready=1. After valid rises, it stays high and addr/we/wdata
//     stay stable until that edge. Valid never drops before the transfer.
//     The ready signal may be high while valid is low, and this has no effect.
//   * bus_resp_valid is a one-cycle strobe with no back-pressure. The
//     requester takes bus_resp_rdata only while it is waiting for a
//     response. At any other time it ignores the strobe.
//   * bus_req_we == 4'b0000 marks a read; any other value marks a write with
//     byte enables (bit 3 = byte at address offset 0).
//
// Modports:
//   master : the bridge (drives the request, receives the response)
//   slave  : the memory / bus model
// ---------------------------------------------------------------------------
interface mips_dmem_bridge_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic [3:0]  bus_req_we;
    logic [31:0] bus_req_wdata;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_rdata;

    modport master (
        output bus_req_valid,
        output bus_req_addr,
        output bus_req_we,
        output bus_req_wdata,
        input  bus_req_ready,
        input  bus_resp_valid,
        input  bus_resp_rdata
    );

    modport slave (
        input  bus_req_valid,
        input  bus_req_addr,
        input  bus_req_we,
        input  bus_req_wdata,
        output bus_req_ready,
        output bus_resp_valid,
        output bus_resp_rdata
    );
endinterface

// File: rtl/mips_dmem_bridge.sv
// ---------------------------------------------------------------------------
// mips_dmem_bridge
//
// This block joins the data-memory port of a pipelined MIPS CPU to a
// valid/ready request bus. The request bus has a separate one-cycle
// response strobe. While a load or store is in flight, the bridge holds
// the CPU pipeline frozen through cpu_en. Load data is registered and
// returned to the CPU M stage.
//
// Ports:
//   clk                 single clock, rising edge
//   rst                 synchronous reset, active low
//   en_in               global run enable from the system
//   cpu_mem_read_en     load request from the CPU X stage
//   cpu_mem_write_en    store byte enables (bit 3 = addr offset 0)
//   cpu_mem_addr        access address (byte address)
//   cpu_mem_write_data  store data
//   cpu_mem_read_data   registered load data
//   cpu_en              CPU enable, 0 = pipeline frozen
//   bus                 request/response bus (master modport)
//   bus_err             sticky timeout flag, cleared only by reset
//   stall_count         wrapping count of cycles with en_in=1 and cpu_en=0
//   state_dbg           current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE)
//
// Parameter:
//   TIMEOUT             the most WAIT cycles allowed before a missing
//                       response is forced to complete with an error
// ---------------------------------------------------------------------------
module mips_dmem_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_in,
    input  logic                      cpu_mem_read_en,
    input  logic [3:0]                cpu_mem_write_en,
    input  logic [31:0]               cpu_mem_addr,
    input  logic [31:0]               cpu_mem_write_data,
    output logic [31:0]               cpu_mem_read_data,
    output logic                      cpu_en,
    mips_dmem_bridge_if.master        bus,
    output logic                      bus_err,
    output logic [31:0]               stall_count,
    output logic [1:0]                state_dbg
);

    // The WAIT counter holds the number of WAIT cycles already spent, so it
    // only has to reach TIMEOUT-1. The timeout fires in the WAIT cycle
    // that sees that value, which is the TIMEOUT-th WAIT cycle.
    localparam int unsigned CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned LAST_WAIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic [31:0]        addr_q,     addr_d;
    logic [3:0]         we_q,       we_d;
    logic [31:0]        wdata_q,    wdata_d;
    logic               rd_q,       rd_d;
    logic [31:0]        rdata_q,    rdata_d;
    logic               err_q,      err_d;
    logic [31:0]        stall_q,    stall_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic               access;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            we_q       <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            stall_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            stall_q    <= stall_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        wait_cnt_d = wait_cnt_q;
        stall_d    = stall_q;
        cpu_en     = 1'b0;

        access = cpu_mem_read_en | (|cpu_mem_write_en);

        unique case (state_q)
            ST_IDLE: begin
                cpu_en = en_in & ~access;
                if (en_in && access) begin
                    // Word-align the address here so the bus sees a
                    // word address.
                    addr_d  = cpu_mem_addr & 32'hFFFF_FFFC;
                    we_d    = cpu_mem_write_en;
                    wdata_d = cpu_mem_write_data;
                    // A store wins over a load raised in the same cycle.
                    rd_d    = (cpu_mem_write_en == 4'b0000);
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (bus.bus_req_ready) begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // If a response arrives in the timeout cycle, the response
                // wins.
                if (bus.bus_resp_valid) begin
                    if (rd_q) begin
                        rdata_d = bus.bus_resp_rdata;
                    end
                    state_d = ST_DONE;
                end else if (wait_cnt_q == CNT_W'(LAST_WAIT)) begin
                    err_d = 1'b1;
                    if (rd_q) begin
                        rdata_d = TIMEOUT_RDATA;
                    end
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                // The CPU still shows the access that just completed, so
                // its request lines are ignored here. The next edge with
                // en_in=1 advances the pipeline past that access.
                cpu_en = en_in;
                if (en_in) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Keep the pipeline frozen while reset is applied.
        if (!rst) begin
            cpu_en = 1'b0;
        end

        if (en_in && !cpu_en) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.bus_req_valid  = (state_q == ST_REQ);
    assign bus.bus_req_addr   = addr_q;
    assign bus.bus_req_we     = we_q;
    assign bus.bus_req_wdata  = wdata_q;

    assign cpu_mem_read_data  = rdata_q;
    assign bus_err            = err_q;
    assign stall_count        = stall_q;
    assign state_dbg          = state_q;

endmodule

// File: doc/mips_dmem_bridge.md
MIPS_DMEM_BRIDGE -- requirements
Module: mips_dmem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent in WAIT before the access is forced to complete.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-low; when rst=0 at a clk edge, all state takes its reset value.
REQ-004 Port en_in, input, 1: global run enable from the system.
REQ-005 Port cpu_mem_read_en, input, 1: read request from the CPU X stage.
REQ-006 Port cpu_mem_write_en, input, 4: byte write enables from the CPU; bit 3 = addr offset 0.
REQ-007 Port cpu_mem_addr, input, 32: access address.
REQ-008 Port cpu_mem_write_data, input, 32: store data.
REQ-009 Port cpu_mem_read_data, output, 32: registered load data to the CPU M stage.
REQ-010 Port cpu_en, output, 1: enable driven to the CPU en input; 0 = pipeline frozen.
REQ-011 Port bus_req_valid, output, 1: request valid.
REQ-012 Port bus_req_ready, input, 1: request accepted.
REQ-013 Port bus_req_addr, output, 32: word address, with bits [1:0] forced to 0.
REQ-014 Port bus_req_we, output, 4: byte enables; all 0 = read.
REQ-015 Port bus_req_wdata, output, 32: write data.
REQ-016 Port bus_resp_valid, input, 1: response strobe, one cycle wide.
REQ-017 Port bus_resp_rdata, input, 32: response data.
REQ-018 Port bus_err, output, 1: sticky timeout flag.
REQ-019 Port stall_count, output, 32: count of cycles with en_in=1 and cpu_en=0.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT and DONE.
REQ-021 An access SHALL be defined as cpu_mem_read_en=1 or cpu_mem_write_en!=0.
REQ-022 IDLE: cpu_en SHALL be en_in & ~access (combinational); if en_in & access, the bridge SHALL capture addr, we (all 0 for a read), wdata and a read flag, then go to REQ.
REQ-023 If read and write are asserted together, the bridge SHALL treat the access as a write and discard the read.
REQ-024 REQ: bus_req_valid=1 with the captured fields, held stable until bus_req_ready=1 at a clk edge; then go to WAIT.
REQ-025 bus_req_valid SHALL be 0 in IDLE, WAIT and DONE, and SHALL never drop before the handshake completes.
REQ-026 WAIT: on bus_resp_valid=1, if the read flag is set, cpu_mem_read_data SHALL load bus_resp_rdata; then go to DONE.
REQ-027 A write response SHALL NOT alter cpu_mem_read_data.
REQ-028 A WAIT cycle counter SHALL clear on entry to WAIT; when it reaches TIMEOUT with no response, the bridge SHALL set bus_err, load 32'hDEADBEEF for a read, and go to DONE.
REQ-029 If bus_resp_valid=1 arrives in the same cycle as the timeout, the response SHALL win and bus_err SHALL NOT be set.
REQ-030 bus_resp_valid seen in IDLE, REQ or DONE SHALL be ignored.
REQ-031 cpu_en SHALL be 0 in REQ and WAIT.
REQ-032 DONE: cpu_en=en_in and the CPU inputs SHALL be ignored, because they still show the completed access; when en_in=1, go to IDLE, otherwise remain in DONE.
REQ-033 cpu_mem_read_data SHALL hold its value until the next read completes, so it is valid in the cycle after DONE.
REQ-034 Minimum access cost SHALL be 3 stalled cycles: entry, REQ with immediate ready, and WAIT with immediate response.
REQ-035 stall_count SHALL increment by 1 in each cycle with en_in=1 and cpu_en=0, and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-036 en_in=0 SHALL NOT abort an access in REQ or WAIT; only DONE and IDLE wait on en_in.

Reset
REQ-037 Reset values: state IDLE, bus_req_valid 0, bus_req_addr/we/wdata 0, cpu_mem_read_data 0, bus_err 0, stall_count 0, WAIT counter 0.
REQ-038 cpu_en SHALL be 0 in any cycle with rst=0.
REQ-039 Reset asserted in REQ or WAIT SHALL abandon the transaction, with no completion and no bus_err.
REQ-040 bus_err SHALL clear only on reset.

Verification
REQ-041 Read, immediate ready and response: addr 0x104, rdata 0x12345678 -> bus_req_addr 0x104, we 0; cpu_en low 3 cycles; cpu_mem_read_data 0x12345678 the cycle after DONE; stall_count 3.
REQ-042 sb to 0x203 (write_en 4'b0001, wdata 0xAAAAAAAA), ready delayed 5 cycles -> bus_req_valid high 6 cycles, fields stable; bus_req_addr 0x200; cpu_mem_read_data unchanged.
REQ-043 Back-to-back lw then sw held on the CPU inputs -> exactly two bus requests; the DONE cycle does not re-issue.
REQ-044 Read with no response, TIMEOUT=4 -> DONE after 4 WAIT cycles; read data 0xDEADBEEF; bus_err=1 and stays 1.
REQ-045 Response coincident with the timeout cycle -> data from the bus; bus_err 0.
REQ-046 rst=0 during WAIT, then a late bus_resp_valid -> state IDLE, response ignored, cpu_mem_read_data 0.
